// File: rtl/cameralink_base_tx_framer.sv
// Camera Link base transmit framer: FVAL/LVAL/DVAL timing and X0..X3 packing.
// Optional CL_TX_TEST_PATTERN_EN adds test_mode and a col/line test pattern.
module cameralink_base_tx_framer #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int H_BLANK  = 64,
  parameter int FV_SETUP = 16,
  parameter int FV_HOLD  = 16,
  parameter int V_BLANK  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
`ifdef CL_TX_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [27:0] tx_data,
  output logic [6:0]  tx_clk_pattern,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSETUP,
    S_LINE,
    S_HBLANK,
    S_FHOLD,
    S_VBLANK
  } state_t;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(FV_SETUP - 1);
  localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(FV_HOLD - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BLANK - 1);

  state_t state, state_nxt;
  logic [CNT_W-1:0] tmr, col, line_cnt;
  logic in_line, xfer, tmr_hit;
  logic col_last, line_last;
  logic fval, lval;
  logic [23:0] px_src, px;
  logic [7:0] a, b, c;
  logic [27:0] word;
  logic fs_nxt, fd_nxt;
  logic [27:0] tx_q;
  logic fs_q, fd_q;

  assign in_line   = (state == S_LINE);
  assign col_last  = (col == H_LAST);
  assign line_last = (line_cnt == V_LAST);

`ifdef CL_TX_TEST_PATTERN_EN
  logic tp_frame;
  logic [7:0] tc, tl;

  assign tc = col[7:0];
  assign tl = line_cnt[7:0];
  assign pix_ready = in_line & ~tp_frame;
  assign xfer = tp_frame ? in_line : (pix_valid & pix_ready);
  assign px_src = tp_frame ? {tl[7:4], tc ^ tl, tl[3:0], tc}
                           : pix_data;

  // mode is latched on entry to FSETUP so it holds for the whole frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      tp_frame <= 1'b0;
    else if (state_nxt == S_FSETUP && state != S_FSETUP)
      tp_frame <= test_mode;
  end
`else
  assign pix_ready = in_line;
  assign xfer = pix_valid & pix_ready;
  assign px_src = pix_data;
`endif

  always_comb begin
    tmr_hit = 1'b0;
    unique case (state)
      S_FSETUP: tmr_hit = (tmr == SU_LAST);
      S_HBLANK: tmr_hit = (tmr == HB_LAST);
      S_FHOLD:  tmr_hit = (tmr == HO_LAST);
      S_VBLANK: tmr_hit = (tmr == VB_LAST);
      default:  tmr_hit = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (enable) state_nxt = S_FSETUP;
      S_FSETUP:
        if (tmr_hit) state_nxt = S_LINE;
      S_LINE:
        if (xfer && col_last)
          state_nxt = line_last ? S_FHOLD : S_HBLANK;
      S_HBLANK:
        if (tmr_hit) state_nxt = S_LINE;
      S_FHOLD:
        if (tmr_hit) state_nxt = S_VBLANK;
      S_VBLANK:
        if (tmr_hit)
          state_nxt = enable ? S_FSETUP : S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tmr      <= '0;
      col      <= '0;
      line_cnt <= '0;
    end else begin
      if (state_nxt != state || state == S_IDLE || in_line)
        tmr <= '0;
      else
        tmr <= tmr + 1'b1;
      if (xfer)
        col <= col_last ? '0 : col + 1'b1;
      if (xfer && col_last && !line_last)
        line_cnt <= line_cnt + 1'b1;
      else if (state == S_FHOLD && tmr_hit)
        line_cnt <= '0;
    end
  end

  always_comb begin
    fval = 1'b0;
    lval = 1'b0;
    unique case (state)
      S_FSETUP, S_HBLANK, S_FHOLD: fval = 1'b1;
      S_LINE: begin
        fval = 1'b1;
        lval = 1'b1;
      end
      default: begin
        fval = 1'b0;
        lval = 1'b0;
      end
    endcase
    px = xfer ? px_src : 24'h0;
    a  = px[7:0];
    b  = {px[23:20], px[11:8]};
    c  = px[19:12];
    word = {
      a[6], a[7], b[6], b[7], c[6], c[7], 1'b0,
      c[2], c[3], c[4], c[5], lval, fval, xfer,
      b[1], b[2], b[3], b[4], b[5], c[0], c[1],
      a[0], a[1], a[2], a[3], a[4], a[5], b[0]
    };
    fs_nxt = (state == S_FSETUP) && (tmr == '0);
    fd_nxt = (state == S_VBLANK) && (tmr == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_q <= '0;
      fs_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      tx_q <= word;
      fs_q <= fs_nxt;
      fd_q <= fd_nxt;
    end
  end

  assign tx_data        = tx_q;
  assign frame_start    = fs_q;
  assign frame_done     = fd_q;
  assign busy           = (state != S_IDLE);
  assign tx_clk_pattern = 7'b1100011;

endmodule

// File: tb/tb_cameralink_base_tx_framer.sv
// Directed bench for cameralink_base_tx_framer with small frame geometry.
// Checks timing bursts, bit packing, underflow, mid-frame reset and pattern.
module tb_cameralink_base_tx_framer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [27:0] tx_data;
  logic [6:0]  tx_clk_pattern;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
`ifdef CL_TX_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 sys_clk = ~sys_clk;

  cameralink_base_tx_framer #(
    .H_ACTIVE(4),
    .V_ACTIVE(2),
    .H_BLANK (2),
    .FV_SETUP(3),
    .FV_HOLD (3),
    .V_BLANK (5),
    .CNT_W   (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .enable        (enable),
`ifdef CL_TX_TEST_PATTERN_EN
    .test_mode     (test_mode),
`endif
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .tx_data       (tx_data),
    .tx_clk_pattern(tx_clk_pattern),
    .frame_start   (frame_start),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  // receive-side unpacking of X0..X3 back to {B[7:4],C,B[3:0],A}
  function automatic logic [23:0] rx_unpack(input logic [27:0] w);
    logic [6:0] x0, x1, x2, x3;
    logic [7:0] a, b, c;
    x0 = w[6:0];
    x1 = w[13:7];
    x2 = w[20:14];
    x3 = w[27:21];
    a = {x3[5], x3[6], x0[1], x0[2], x0[3], x0[4], x0[5], x0[6]};
    b = {x3[3], x3[4], x1[2], x1[3], x1[4], x1[5], x1[6], x0[0]};
    c = {x3[1], x3[2], x2[3], x2[4], x2[5], x2[6], x1[0], x1[1]};
    return {b[7:4], c, b[3:0], a};
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1;
    enable = 1'b0;
    pix_valid = 1'b0;
    pix_data = 24'h0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tx_data !== 28'h0) begin
      bad++;
      $display("FAIL reset_tx got=%h want=0", tx_data);
    end
    total++;
    if ({busy, pix_ready, frame_start, frame_done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000",
               {busy, pix_ready, frame_start, frame_done});
    end
    total++;
    if (tx_clk_pattern !== 7'b1100011) begin
      bad++;
      $display("FAIL clk_pattern got=%b want=1100011", tx_clk_pattern);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] fv, lv, dv, fs, fd, bz;
    fv = '0; lv = '0; dv = '0;
    fs = '0; fd = '0; bz = '0;
    do_reset();
    pix_valid = 1'b1;
    pix_data = 24'h123456;
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      enable = 1'b0;
      fv[i] = tx_data[15];
      lv[i] = tx_data[16];
      dv[i] = tx_data[14];
      fs[i] = frame_start;
      fd[i] = frame_done;
      bz[i] = busy;
    end
    total++;
    if (fv !== 32'h0001FFFE) begin
      bad++;
      $display("FAIL frame_fval got=%h want=0001fffe", fv);
    end
    total++;
    if (lv !== 32'h00003CF0) begin
      bad++;
      $display("FAIL frame_lval got=%h want=00003cf0", lv);
    end
    total++;
    if (dv !== 32'h00003CF0) begin
      bad++;
      $display("FAIL frame_dval got=%h want=00003cf0", dv);
    end
    total++;
    if (fs !== 32'h00000002) begin
      bad++;
      $display("FAIL frame_start got=%h want=00000002", fs);
    end
    total++;
    if (fd !== 32'h00020000) begin
      bad++;
      $display("FAIL frame_done got=%h want=00020000", fd);
    end
    total++;
    if (bz !== 32'h001FFFFF) begin
      bad++;
      $display("FAIL frame_busy got=%h want=001fffff", bz);
    end
  endtask

  task automatic test_back_to_back();
    int t[8];
    int n;
    logic busy_all;
    n = 0;
    busy_all = 1'b1;
    do_reset();
    pix_valid = 1'b1;
    pix_data = 24'h0F0F0F;
    enable = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge sys_clk);
      busy_all &= busy;
      if (frame_start && n < 8) begin
        t[n] = i;
        n++;
      end
    end
    enable = 1'b0;
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=4", n);
    end
    total++;
    if (n > 0 && t[0] !== 1) begin
      bad++;
      $display("FAIL b2b_first got=%0d want=1", t[0]);
    end
    for (int k = 1; k < 4; k++) begin
      total++;
      if (k < n && (t[k] - t[k-1]) !== 21) begin
        bad++;
        $display("FAIL b2b_period%0d got=%0d want=21", k, t[k] - t[k-1]);
      end
    end
    total++;
    if (busy_all !== 1'b1) begin
      bad++;
      $display("FAIL b2b_busy got=0 want=1");
    end
  endtask

  task automatic test_mapping();
    logic found;
    logic [27:0] w;
    logic rdy;
    found = 1'b0;
    w = '0;
    rdy = 1'b0;
    do_reset();
    pix_valid = 1'b1;
    pix_data = 24'hA5C33C;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      enable = 1'b0;
      if (tx_data[14] && !found) begin
        found = 1'b1;
        w = tx_data;
        rdy = pix_ready;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL map_timeout got=none want=dval_word");
    end
    total++;
    if (w !== {7'b0001100, 7'b1110111, 7'b1000100, 7'b0011111}) begin
      bad++;
      $display("FAIL map_word got=%b want=%b", w,
               {7'b0001100, 7'b1110111, 7'b1000100, 7'b0011111});
    end
    total++;
    if (rx_unpack(w) !== 24'hA5C33C) begin
      bad++;
      $display("FAIL map_roundtrip got=%h want=a5c33c", rx_unpack(w));
    end
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL map_ready got=%b want=1", rdy);
    end
  endtask

  task automatic test_underflow();
    int ridx, bursts, lcnt, zero_ok, fcnt, dcnt;
    logic prev_l;
    logic [7:0] dvec;
    ridx = 0; bursts = 0; lcnt = 0;
    zero_ok = 0; fcnt = 0; dcnt = 0;
    prev_l = 1'b0;
    dvec = '0;
    do_reset();
    pix_valid = 1'b1;
    pix_data = 24'hFFFFFF;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      enable = 1'b0;
      if (tx_data[15]) fcnt++;
      if (tx_data[14]) dcnt++;
      if (tx_data[16] && !prev_l) bursts++;
      if (tx_data[16] && bursts == 1 && lcnt < 8) begin
        dvec[lcnt] = tx_data[14];
        if (!tx_data[14] && (tx_data & ~28'h001C000) == 28'h0)
          zero_ok++;
        lcnt++;
      end
      prev_l = tx_data[16];
      if (pix_ready) begin
        pix_valid = !(ridx >= 2 && ridx <= 4);
        ridx++;
      end else begin
        pix_valid = 1'b1;
      end
    end
    total++;
    if (lcnt !== 7) begin
      bad++;
      $display("FAIL uf_line_len got=%0d want=7", lcnt);
    end
    total++;
    if (dvec !== 8'b01100011) begin
      bad++;
      $display("FAIL uf_dval got=%b want=01100011", dvec);
    end
    total++;
    if (zero_ok !== 3) begin
      bad++;
      $display("FAIL uf_zero got=%0d want=3", zero_ok);
    end
    total++;
    if (fcnt !== 19) begin
      bad++;
      $display("FAIL uf_fval got=%0d want=19", fcnt);
    end
    total++;
    if (dcnt !== 8) begin
      bad++;
      $display("FAIL uf_dcount got=%0d want=8", dcnt);
    end
  endtask

  task automatic test_mid_reset();
    int bursts;
    logic prev_l, found, fd_seen;
    logic [3:0] fv, lv, fs;
    bursts = 0;
    prev_l = 1'b0;
    found = 1'b0;
    fd_seen = 1'b0;
    fv = '0; lv = '0; fs = '0;
    do_reset();
    pix_valid = 1'b1;
    pix_data = 24'h55AA55;
    enable = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge sys_clk);
      enable = 1'b0;
      if (tx_data[16] && !prev_l) bursts++;
      prev_l = tx_data[16];
      if (bursts == 2) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL mr_timeout got=none want=line1");
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    total++;
    if (tx_data !== 28'h0) begin
      bad++;
      $display("FAIL mr_tx got=%h want=0", tx_data);
    end
    total++;
    if ({busy, pix_ready, frame_start} !== 3'b0) begin
      bad++;
      $display("FAIL mr_ctl got=%b want=000",
               {busy, pix_ready, frame_start});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      fd_seen |= frame_done | busy;
    end
    total++;
    if (fd_seen !== 1'b0) begin
      bad++;
      $display("FAIL mr_idle got=1 want=0");
    end
    enable = 1'b1;
    @(negedge sys_clk);
    enable = 1'b0;
    total++;
    if ({busy, tx_data[15]} !== 2'b10) begin
      bad++;
      $display("FAIL mr_restart got=%b want=10", {busy, tx_data[15]});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      fv[i] = tx_data[15];
      lv[i] = tx_data[16];
      fs[i] = frame_start;
    end
    total++;
    if ({fv, lv, fs} !== {4'b1111, 4'b1000, 4'b0001}) begin
      bad++;
      $display("FAIL mr_setup got=%b_%b_%b want=1111_1000_0001", fv, lv, fs);
    end
  endtask

`ifdef CL_TX_TEST_PATTERN_EN
  task automatic test_pattern();
    int bursts, lcol, bad_dv;
    logic prev_l, rdy_seen, got;
    logic [27:0] w;
    logic [23:0] d;
    bursts = 0; lcol = 0; bad_dv = 0;
    prev_l = 1'b0; rdy_seen = 1'b0; got = 1'b0;
    w = '0;
    do_reset();
    pix_valid = 1'b1;
    pix_data = 24'hFFFFFF;
    test_mode = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      enable = 1'b0;
      test_mode = 1'b0;
      rdy_seen |= pix_ready;
      if (tx_data[16] && !prev_l) begin
        bursts++;
        lcol = 0;
      end
      if (tx_data[16]) begin
        if (!tx_data[14]) bad_dv++;
        if (bursts == 2 && lcol == 2) begin
          w = tx_data;
          got = 1'b1;
        end
        lcol++;
      end
      prev_l = tx_data[16];
    end
    d = rx_unpack(w);
    total++;
    if (rdy_seen !== 1'b0) begin
      bad++;
      $display("FAIL tp_ready got=1 want=0");
    end
    total++;
    if (bad_dv !== 0 || !got) begin
      bad++;
      $display("FAIL tp_dval got=%0d/%b want=0/1", bad_dv, got);
    end
    total++;
    if ({d[7:0], d[23:20], d[11:8], d[19:12]} !== 24'h020103) begin
      bad++;
      $display("FAIL tp_payload got=%h want=020103",
               {d[7:0], d[23:20], d[11:8], d[19:12]});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mapping();
    test_underflow();
    test_mid_reset();
`ifdef CL_TX_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
